// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry 2-bit counters; bimodal indexing by default.
// Define BP_GSHARE_EN to XOR the index with a global history register (gshare).
module branch_predictor #(
  parameter int unsigned ENTRIES = 64,
  parameter int unsigned XLEN    = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [XLEN-1:0]            if_pc,
  output logic                       pred_taken,
  output logic [XLEN-1:0]            pred_target,
  output logic [$clog2(ENTRIES)-1:0] pred_ghr,
  input  logic                       upd_valid,
  input  logic                       upd_cond,
  input  logic [XLEN-1:0]            upd_pc,
  input  logic                       upd_taken,
  input  logic [XLEN-1:0]            upd_target,
  input  logic                       upd_pred_taken,
  input  logic [XLEN-1:0]            upd_pred_target,
  input  logic [$clog2(ENTRIES)-1:0] upd_ghr,
  output logic                       mispredict,
  output logic [XLEN-1:0]            redirect_pc,
  output logic [31:0]                branch_cnt,
  output logic [31:0]                miss_cnt
);
  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = XLEN - IDX_W - 2;

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [XLEN-1:0]  target_q [ENTRIES];
  logic             uncond_q [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];

  logic [IDX_W-1:0] li, ui;

`ifdef BP_GSHARE_EN
  logic [IDX_W-1:0] ghr_q, ghr_d;

  assign li       = if_pc[IDX_W+1:2] ^ ghr_q;
  assign ui       = upd_pc[IDX_W+1:2] ^ upd_ghr;
  assign pred_ghr = ghr_q;

  always_comb begin
    ghr_d = ghr_q;
    if (upd_valid && upd_cond) ghr_d = {ghr_q[IDX_W-2:0], upd_taken};
  end

  always_ff @(posedge clk) begin
    if (rst_n) ghr_q <= '0;
    else       ghr_q <= ghr_d;
  end
`else
  logic unused_upd_ghr;

  assign unused_upd_ghr = ^upd_ghr;
  assign li             = if_pc[IDX_W+1:2];
  assign ui             = upd_pc[IDX_W+1:2];
  assign pred_ghr       = '0;
`endif

  // Lookup path
  logic l_hit;

  always_comb begin
    l_hit       = valid_q[li] && (tag_q[li] == if_pc[XLEN-1:IDX_W+2]);
    pred_taken  = l_hit && (uncond_q[li] || ctr_q[li][1]);
    pred_target = pred_taken ? target_q[li] : if_pc + XLEN'(4);
  end

  // Update path: next contents of entry ui
  logic            u_hit, tbl_we;
  logic [XLEN-1:0] target_d;
  logic            uncond_d;
  logic [1:0]      ctr_d;

  always_comb begin
    u_hit    = valid_q[ui] && (tag_q[ui] == upd_pc[XLEN-1:IDX_W+2]);
    tbl_we   = 1'b0;
    target_d = target_q[ui];
    uncond_d = uncond_q[ui];
    ctr_d    = ctr_q[ui];
    if (upd_valid) begin
      if (!u_hit) begin
        if (upd_taken) begin
          tbl_we   = 1'b1;
          target_d = upd_target;
          uncond_d = ~upd_cond;
          ctr_d    = 2'b10;
        end
      end else if (upd_cond) begin
        tbl_we = 1'b1;
        if (upd_taken) begin
          target_d = upd_target;
          if (ctr_q[ui] != 2'b11) ctr_d = ctr_q[ui] + 2'd1;
        end else if (ctr_q[ui] != 2'b00) begin
          ctr_d = ctr_q[ui] - 2'd1;
        end
      end else begin
        tbl_we   = 1'b1;
        target_d = upd_target;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= 2'b00;
      end
    end else if (tbl_we) begin
      valid_q[ui]  <= 1'b1;
      tag_q[ui]    <= upd_pc[XLEN-1:IDX_W+2];
      target_q[ui] <= target_d;
      uncond_q[ui] <= uncond_d;
      ctr_q[ui]    <= ctr_d;
    end
  end

  // Resolution and statistics; rst_n is active-high, so !rst_n means running
  logic [31:0] branch_cnt_q, branch_cnt_d, miss_cnt_q, miss_cnt_d;

  always_comb begin
    mispredict   = !rst_n && upd_valid &&
                   ((upd_taken != upd_pred_taken) ||
                    (upd_taken && (upd_target != upd_pred_target)));
    redirect_pc  = upd_taken ? upd_target : upd_pc + XLEN'(4);
    branch_cnt_d = branch_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    if (upd_valid && (branch_cnt_q != 32'hFFFF_FFFF)) branch_cnt_d = branch_cnt_q + 32'd1;
    if (mispredict && (miss_cnt_q != 32'hFFFF_FFFF)) miss_cnt_d = miss_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      branch_cnt_q <= '0;
      miss_cnt_q   <= '0;
    end else begin
      branch_cnt_q <= branch_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  assign branch_cnt = branch_cnt_q;
  assign miss_cnt   = miss_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed testbench for branch_predictor (ENTRIES=64, XLEN=32); covers both builds.
module tb_branch_predictor;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic [5:0]  pred_ghr;
  logic        upd_valid, upd_cond, upd_taken, upd_pred_taken;
  logic [31:0] upd_pc, upd_target, upd_pred_target;
  logic [5:0]  upd_ghr;
  logic        mispredict;
  logic [31:0] redirect_pc, branch_cnt, miss_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  branch_predictor #(.ENTRIES(64), .XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc),
    .pred_taken(pred_taken), .pred_target(pred_target), .pred_ghr(pred_ghr),
    .upd_valid(upd_valid), .upd_cond(upd_cond), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
    .upd_pred_target(upd_pred_target), .upd_ghr(upd_ghr),
    .mispredict(mispredict), .redirect_pc(redirect_pc),
    .branch_cnt(branch_cnt), .miss_cnt(miss_cnt)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic c, input logic [31:0] pc, input logic t, input logic [31:0] tg,
                     input logic pt, input logic [31:0] ptg, input logic [5:0] g);
    upd_valid = 1'b1; upd_cond = c; upd_pc = pc; upd_taken = t; upd_target = tg;
    upd_pred_taken = pt; upd_pred_target = ptg; upd_ghr = g;
  endtask

  task automatic idle;
    upd_valid = 1'b0;
  endtask

  task automatic do_reset;
    rst_n = 1'b1; idle; tick; rst_n = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    if_pc = 32'h100;
    upd(1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104, 6'd0);
    @(negedge clk);
    total++; if (mispredict !== 1'b0) begin bad++; $display("FAIL rst_mispredict_gate got=%b want=0", mispredict); end
    tick;
    rst_n = 1'b0; idle;
    @(negedge clk);
    total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL rst_pred_taken got=%b want=0", pred_taken); end
    total++; if (pred_target !== 32'h104) begin bad++; $display("FAIL rst_pred_target got=%h want=104", pred_target); end
    total++; if (pred_ghr !== 6'd0) begin bad++; $display("FAIL rst_pred_ghr got=%h want=0", pred_ghr); end
    total++; if (branch_cnt !== 32'd0) begin bad++; $display("FAIL rst_branch_cnt got=%0d want=0", branch_cnt); end
    total++; if (miss_cnt !== 32'd0) begin bad++; $display("FAIL rst_miss_cnt got=%0d want=0", miss_cnt); end
    tick;
  endtask

  task automatic test_alloc;
    if_pc = 32'h100;
    upd(1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104, 6'd0);
    @(negedge clk);
    total++; if (mispredict !== 1'b1) begin bad++; $display("FAIL alloc_mispredict got=%b want=1", mispredict); end
    total++; if (redirect_pc !== 32'h80) begin bad++; $display("FAIL alloc_redirect got=%h want=80", redirect_pc); end
    total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL same_cycle_old_pred got=%b want=0", pred_taken); end
    tick;
    idle;
    @(negedge clk);
    total++; if (pred_taken !== 1'b1) begin bad++; $display("FAIL alloc_pred_taken got=%b want=1", pred_taken); end
    total++; if (pred_target !== 32'h80) begin bad++; $display("FAIL alloc_pred_target got=%h want=80", pred_target); end
    total++; if (branch_cnt !== 32'd1) begin bad++; $display("FAIL alloc_branch_cnt got=%0d want=1", branch_cnt); end
    total++; if (miss_cnt !== 32'd1) begin bad++; $display("FAIL alloc_miss_cnt got=%0d want=1", miss_cnt); end
    tick;
  endtask

  task automatic test_saturation;
    do_reset;
    if_pc = 32'h100;
    for (int i = 0; i < 4; i++) begin
      upd(1'b1, 32'h100, 1'b1, 32'h80, (i != 0), (i == 0) ? 32'h104 : 32'h80, 6'd0);
      @(negedge clk);
      total++; if (mispredict !== (i == 0)) begin bad++; $display("FAIL sat_taken_mispredict[%0d] got=%b want=%b", i, mispredict, (i == 0)); end
      tick;
    end
    idle;
    @(negedge clk);
    total++; if (pred_taken !== 1'b1) begin bad++; $display("FAIL sat_after4_taken got=%b want=1", pred_taken); end
    tick;
    upd(1'b1, 32'h100, 1'b0, 32'h0, 1'b1, 32'h80, 6'd0);
    @(negedge clk);
    total++; if (mispredict !== 1'b1) begin bad++; $display("FAIL sat_nt1_mispredict got=%b want=1", mispredict); end
    total++; if (redirect_pc !== 32'h104) begin bad++; $display("FAIL sat_nt1_redirect got=%h want=104", redirect_pc); end
    tick;
    idle;
    @(negedge clk);
    total++; if (pred_taken !== 1'b1) begin bad++; $display("FAIL sat_ctr10_taken got=%b want=1", pred_taken); end
    tick;
    upd(1'b1, 32'h100, 1'b0, 32'h0, 1'b1, 32'h80, 6'd0);
    tick;
    idle;
    @(negedge clk);
    total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL sat_ctr01_taken got=%b want=0", pred_taken); end
    total++; if (pred_target !== 32'h104) begin bad++; $display("FAIL sat_ctr01_target got=%h want=104", pred_target); end
    total++; if (branch_cnt !== 32'd6) begin bad++; $display("FAIL sat_branch_cnt got=%0d want=6", branch_cnt); end
    total++; if (miss_cnt !== 32'd3) begin bad++; $display("FAIL sat_miss_cnt got=%0d want=3", miss_cnt); end
    tick;
  endtask

  task automatic test_alias;
    // Entry at 0x100 holds ctr=01; one taken update raises it to 10
    upd(1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104, 6'd0);
    tick;
    idle;
    if_pc = 32'h100;
    @(negedge clk);
    total++; if (pred_taken !== 1'b1) begin bad++; $display("FAIL alias_base_taken got=%b want=1", pred_taken); end
    if_pc = 32'h200;
    #1;
    total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL alias_tag_miss got=%b want=0", pred_taken); end
    total++; if (pred_target !== 32'h204) begin bad++; $display("FAIL alias_tag_miss_tgt got=%h want=204", pred_target); end
    tick;
    upd(1'b0, 32'h200, 1'b1, 32'h40, 1'b0, 32'h204, 6'd0);
    @(negedge clk);
    total++; if (redirect_pc !== 32'h40) begin bad++; $display("FAIL alias_jal_redirect got=%h want=40", redirect_pc); end
    tick;
    idle;
    if_pc = 32'h200;
    @(negedge clk);
    total++; if (pred_target !== 32'h40) begin bad++; $display("FAIL alias_jal_target got=%h want=40", pred_target); end
    if_pc = 32'h100;
    #1;
    total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL alias_evicted got=%b want=0", pred_taken); end
    tick;
    upd(1'b0, 32'h200, 1'b1, 32'h60, 1'b1, 32'h40, 6'd0);
    @(negedge clk);
    total++; if (mispredict !== 1'b1) begin bad++; $display("FAIL jal_tgt_mispredict got=%b want=1", mispredict); end
    tick;
    upd(1'b1, 32'h200, 1'b0, 32'h0, 1'b1, 32'h60, 6'd0);
    tick;
    tick;
    idle;
    if_pc = 32'h200;
    @(negedge clk);
    total++; if (pred_taken !== 1'b1) begin bad++; $display("FAIL uncond_keeps_taken got=%b want=1", pred_taken); end
    total++; if (pred_target !== 32'h60) begin bad++; $display("FAIL jal_tgt_overwrite got=%h want=60", pred_target); end
    tick;
  endtask

  task automatic test_not_taken_miss;
    if_pc = 32'h104;
    upd(1'b1, 32'h104, 1'b0, 32'h0, 1'b0, 32'h108, 6'd0);
    @(negedge clk);
    total++; if (mispredict !== 1'b0) begin bad++; $display("FAIL nt_miss_mispredict got=%b want=0", mispredict); end
    total++; if (redirect_pc !== 32'h108) begin bad++; $display("FAIL nt_miss_redirect got=%h want=108", redirect_pc); end
    tick;
    idle;
    @(negedge clk);
    total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL nt_miss_no_alloc got=%b want=0", pred_taken); end
    tick;
  endtask

  task automatic test_ghr;
    do_reset;
`ifdef BP_GSHARE_EN
    for (int i = 0; i < 3; i++) begin
      upd(1'b1, 32'h104, 1'b1, 32'h300, 1'b0, 32'h108, 6'd0);
      tick;
    end
    idle;
    @(negedge clk);
    total++; if (pred_ghr !== 6'h07) begin bad++; $display("FAIL ghr_three_taken got=%h want=07", pred_ghr); end
    tick;
    upd(1'b1, 32'h100, 1'b1, 32'h500, 1'b0, 32'h104, 6'd5);
    tick;
    idle;
    // GHR is now 0x0f; 0x128 indexes 10^15 = 5 with the same tag as 0x100
    if_pc = 32'h128;
    @(negedge clk);
    total++; if (pred_ghr !== 6'h0f) begin bad++; $display("FAIL ghr_four_taken got=%h want=0f", pred_ghr); end
    total++; if (pred_taken !== 1'b1) begin bad++; $display("FAIL gshare_idx_taken got=%b want=1", pred_taken); end
    total++; if (pred_target !== 32'h500) begin bad++; $display("FAIL gshare_idx_target got=%h want=500", pred_target); end
`else
    upd(1'b1, 32'h108, 1'b1, 32'h500, 1'b0, 32'h10c, 6'd5);
    tick;
    idle;
    if_pc = 32'h108;
    @(negedge clk);
    total++; if (pred_ghr !== 6'd0) begin bad++; $display("FAIL bimodal_ghr_zero got=%h want=0", pred_ghr); end
    total++; if (pred_taken !== 1'b1) begin bad++; $display("FAIL bimodal_ignores_ghr got=%b want=1", pred_taken); end
    total++; if (pred_target !== 32'h500) begin bad++; $display("FAIL bimodal_target got=%h want=500", pred_target); end
`endif
    tick;
  endtask

  initial begin
    rst_n = 1'b1; if_pc = '0; upd_valid = 1'b0; upd_cond = 1'b0; upd_pc = '0;
    upd_taken = 1'b0; upd_target = '0; upd_pred_taken = 1'b0; upd_pred_target = '0;
    upd_ghr = '0;
    tick;
    tick;
    test_reset;
    test_alloc;
    test_saturation;
    test_alias;
    test_not_taken_miss;
    test_ghr;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
